// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial A - B, LSB first, one full-subtractor cell plus borrow register
// Result, final borrow and signed overflow are held from DONE until the next accepted start.
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow_out,
   output logic             overflow
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_next;
   logic [WIDTH-1:0] r_a_sr;
   logic [WIDTH-1:0] r_b_sr;
   logic [WIDTH-1:0] r_diff;
   logic             r_a_msb;
   logic             r_b_msb;
   logic             r_borrow;
   logic             r_borrow_out;
   logic             r_overflow;
   logic [CW-1:0]    r_cnt;

   logic w_x;
   logic w_y;
   logic w_d;
   logic w_borrow_next;
   logic w_last;

   assign w_x           = r_a_sr[0];
   assign w_y           = r_b_sr[0];
   assign w_d           = w_x ^ w_y ^ r_borrow;
   assign w_borrow_next = (~w_x & w_y) | (~(w_x ^ w_y) & r_borrow);
   assign w_last        = (r_cnt == CW'(WIDTH - 1));

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (start) w_next = S_SHIFT;
         S_SHIFT: if (w_last) w_next = S_DONE;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_comb begin
      busy = (r_state == S_SHIFT);
      done = (r_state == S_DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_a_sr       <= '0;
         r_b_sr       <= '0;
         r_diff       <= '0;
         r_a_msb      <= 1'b0;
         r_b_msb      <= 1'b0;
         r_borrow     <= 1'b0;
         r_borrow_out <= 1'b0;
         r_overflow   <= 1'b0;
         r_cnt        <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_a_sr       <= a;
                  r_b_sr       <= b;
                  r_a_msb      <= a[WIDTH-1];
                  r_b_msb      <= b[WIDTH-1];
                  r_diff       <= '0;
                  r_borrow     <= 1'b0;
                  r_borrow_out <= 1'b0;
                  r_overflow   <= 1'b0;
                  r_cnt        <= '0;
               end
            end
            S_SHIFT: begin
               r_diff   <= {w_d, r_diff[WIDTH-1:1]};
               r_a_sr   <= {1'b0, r_a_sr[WIDTH-1:1]};
               r_b_sr   <= {1'b0, r_b_sr[WIDTH-1:1]};
               r_borrow <= w_borrow_next;
               r_cnt    <= r_cnt + CW'(1);
               // The bit shifted in on the last step becomes the result MSB.
               if (w_last) begin
                  r_borrow_out <= w_borrow_next;
                  r_overflow   <= (r_a_msb != r_b_msb) & (w_d != r_a_msb);
               end
            end
            default: ;
         endcase
      end
   end

   assign diff       = r_diff;
   assign borrow_out = r_borrow_out;
   assign overflow   = r_overflow;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - self-checking bench for serial_subtractor (WIDTH=8 and WIDTH=2)
module tb_serial_subtractor;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       st8 = 1'b0;
   logic [7:0] a8 = '0;
   logic [7:0] b8 = '0;
   logic       busy8, done8, bo8, ov8;
   logic [7:0] diff8;
   logic       st2 = 1'b0;
   logic [1:0] a2 = '0;
   logic [1:0] b2 = '0;
   logic       busy2, done2, bo2, ov2;
   logic [1:0] diff2;

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   serial_subtractor #(.WIDTH(8)) u_dut8 (
      .clk(clk), .rst(rst), .start(st8), .a(a8), .b(b8),
      .busy(busy8), .done(done8), .diff(diff8), .borrow_out(bo8), .overflow(ov8)
   );

   serial_subtractor #(.WIDTH(2)) u_dut2 (
      .clk(clk), .rst(rst), .start(st2), .a(a2), .b(b2),
      .busy(busy2), .done(done2), .diff(diff2), .borrow_out(bo2), .overflow(ov2)
   );

   // Reference: plain integer arithmetic on unsigned and signed interpretations.
   function automatic void model(input int w, input int ia, input int ib,
                                 output int d, output logic bo, output logic ov);
      int m, sa, sb, r;
      m  = 1 << w;
      d  = (ia - ib + m) % m;
      bo = (ia < ib);
      sa = (ia >= m / 2) ? ia - m : ia;
      sb = (ib >= m / 2) ? ib - m : ib;
      r  = sa - sb;
      ov = (r > m / 2 - 1) || (r < -(m / 2));
   endfunction

   // One WIDTH=8 operation; inputs are scrambled right after acceptance.
   task automatic run8(input logic [7:0] ia, input logic [7:0] ib, output logic [7:0] d,
                       output logic bo, output logic ov, output int lat, output logic extra);
      @(negedge clk);
      a8 = ia; b8 = ib; st8 = 1'b1;
      @(negedge clk);
      st8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
      lat = 0;
      while (done8 !== 1'b1 && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      d = diff8; bo = bo8; ov = ov8;
      @(posedge clk); #1;
      extra = done8;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++; if ({busy8, done8, bo8, ov8} !== 4'b0) begin errors++; $display("FAIL reset_flags8 got=%b exp=0000", {busy8, done8, bo8, ov8}); end
      checks++; if (diff8 !== 8'h00) begin errors++; $display("FAIL reset_diff8 got=%h exp=00", diff8); end
      checks++; if ({busy2, done2, bo2, ov2, diff2} !== 6'b0) begin errors++; $display("FAIL reset_all2 got=%b exp=000000", {busy2, done2, bo2, ov2, diff2}); end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_vectors();
      logic [7:0] va [6] = '{8'd200, 8'd5, 8'd0, 8'h80, 8'h7F, 8'd7};
      logic [7:0] vb [6] = '{8'd55,  8'd9, 8'd1, 8'h01, 8'hFF, 8'd7};
      logic [7:0] d; logic bo, ov, extra; int lat, ed; logic ebo, eov;
      for (int i = 0; i < 6; i++) begin
         run8(va[i], vb[i], d, bo, ov, lat, extra);
         model(8, int'(va[i]), int'(vb[i]), ed, ebo, eov);
         checks++; if (lat !== 8) begin errors++; $display("FAIL vec%0d_latency got=%0d exp=8", i, lat); end
         checks++; if (d !== 8'(ed)) begin errors++; $display("FAIL vec%0d_diff got=%h exp=%h", i, d, 8'(ed)); end
         checks++; if ({bo, ov} !== {ebo, eov}) begin errors++; $display("FAIL vec%0d_flags got=%b exp=%b", i, {bo, ov}, {ebo, eov}); end
         checks++; if (extra !== 1'b0) begin errors++; $display("FAIL vec%0d_done_pulse got=%b exp=0", i, extra); end
      end
   endtask

   task automatic test_random();
      logic [7:0] ra, rb, d; logic bo, ov, extra, ebo, eov; int lat, ed;
      for (int i = 0; i < 25; i++) begin
         ra = 8'($urandom); rb = 8'($urandom);
         run8(ra, rb, d, bo, ov, lat, extra);
         model(8, int'(ra), int'(rb), ed, ebo, eov);
         checks++; if (d !== 8'(ed) || {bo, ov} !== {ebo, eov} || lat !== 8)
            begin errors++; $display("FAIL rand%0d %h-%h got=%h/%b%b/%0d exp=%h/%b%b/8", i, ra, rb, d, bo, ov, lat, 8'(ed), ebo, eov); end
      end
   endtask

   task automatic test_ignore_start();
      int ndone = 0; logic prev_done = 1'b0; logic [7:0] d = '0; logic bo = 1'b0, ov = 1'b0;
      @(negedge clk);
      a8 = 8'd100; b8 = 8'd1; st8 = 1'b1;
      for (int c = 1; c <= 24; c++) begin
         @(negedge clk);
         st8 = (c == 4) || prev_done;
         if (c == 4) begin a8 = 8'd3; b8 = 8'd7; end
         else begin a8 = 8'($urandom); b8 = 8'($urandom); end
         @(posedge clk); #1;
         if (done8 === 1'b1) begin ndone++; d = diff8; bo = bo8; ov = ov8; end
         prev_done = done8;
      end
      @(negedge clk);
      st8 = 1'b0;
      checks++; if (ndone !== 1) begin errors++; $display("FAIL ignore_done_count got=%0d exp=1", ndone); end
      checks++; if (d !== 8'd99) begin errors++; $display("FAIL ignore_diff got=%0d exp=99", d); end
      checks++; if ({bo, ov, busy8} !== 3'b000) begin errors++; $display("FAIL ignore_flags got=%b exp=000", {bo, ov, busy8}); end
   endtask

   task automatic test_reset_mid();
      int ndone = 0; logic [7:0] d; logic bo, ov, extra; int lat;
      @(negedge clk);
      a8 = 8'd50; b8 = 8'd20; st8 = 1'b1;
      @(negedge clk);
      st8 = 1'b0;
      repeat (4) @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      checks++; if ({busy8, done8, bo8, ov8} !== 4'b0) begin errors++; $display("FAIL midrst_flags got=%b exp=0000", {busy8, done8, bo8, ov8}); end
      checks++; if (diff8 !== 8'h00) begin errors++; $display("FAIL midrst_diff got=%h exp=00", diff8); end
      @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 15; c++) begin
         @(posedge clk); #1;
         if (done8 === 1'b1 || busy8 === 1'b1) ndone++;
      end
      checks++; if (ndone !== 0) begin errors++; $display("FAIL midrst_activity got=%0d exp=0", ndone); end
      run8(8'd7, 8'd3, d, bo, ov, lat, extra);
      checks++; if (d !== 8'd4 || lat !== 8) begin errors++; $display("FAIL midrst_recover got=%0d/%0d exp=4/8", d, lat); end
   endtask

   task automatic test_back_to_back();
      int k, acc, prev_acc, ed; logic ebo, eov;
      prev_acc = -1;
      @(negedge clk);
      a2 = 2'd0; b2 = 2'd0; st2 = 1'b1;
      for (int i = 0; i < 16; i++) begin
         k = 0;
         while (busy2 !== 1'b1 && k < 10) begin @(posedge clk); #1; k++; end
         acc = cyc;
         if (i > 0) begin
            checks++; if (acc - prev_acc !== 4) begin errors++; $display("FAIL b2b%0d_interval got=%0d exp=4", i, acc - prev_acc); end
         end
         prev_acc = acc;
         @(negedge clk);
         if (i < 15) begin a2 = 2'((i + 1) >> 2); b2 = 2'((i + 1) & 3); end
         else begin a2 = 2'($urandom); b2 = 2'($urandom); end
         k = 0;
         while (done2 !== 1'b1 && k < 10) begin @(posedge clk); #1; k++; end
         model(2, i >> 2, i & 3, ed, ebo, eov);
         checks++; if (diff2 !== 2'(ed) || {bo2, ov2} !== {ebo, eov})
            begin errors++; $display("FAIL b2b%0d %0d-%0d got=%0d/%b%b exp=%0d/%b%b", i, i >> 2, i & 3, diff2, bo2, ov2, ed, ebo, eov); end
      end
      @(negedge clk);
      st2 = 1'b0;
   endtask

   initial begin
      test_reset();
      test_vectors();
      test_random();
      test_ignore_start();
      test_reset_mid();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
